// File: rtl/ts_stub_writer.sv
// ---------------------------------------------------------------------------
// ts_stub_writer
//
// Producer side of the per-crossing stub hand-off in the trigger stub path.
// Stubs of one bunch crossing are gathered into one half of a ping-pong
// buffer. At the end of the crossing the filled half and its stub count are
// handed to the processing side, which reads the stubs back by address and
// releases the half with proc_done.
//
// Parameters
//   STUB_W    stub word width
//   CNT_BITS  stub count width; each bank stores at most 2^CNT_BITS-1 stubs
//
// Ports
//   clk        in   processing clock, all logic on rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_data carries a stub this cycle
//   in_data    in   stub word
//   in_bx_end  in   last cycle of the current crossing
//   proc_done  in   consumer has finished with the bank it was handed (pulse)
//   rd_addr    in   read index into the handed-off bank
//   rd_data    out  registered read data (1 cycle latency)
//   out_ld     out  hand-off pulse, drives the consumer's ld_en
//   out_cnt    out  stub count of the handed-off bank, drives consumer init
//   out_bank   out  bank currently owned by the reader
//   out_ovf    out  handed-off crossing exceeded the bank capacity
//   drop_stub  out  a stub was discarded (overflow or while holding)
//   lost_bx    out  a whole crossing was discarded while holding
// ---------------------------------------------------------------------------
module ts_stub_writer #(
  parameter int STUB_W   = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [STUB_W-1:0]   in_data,
  input  logic                in_bx_end,
  input  logic                proc_done,
  input  logic [CNT_BITS-1:0] rd_addr,
  output logic [STUB_W-1:0]   rd_data,
  output logic                out_ld,
  output logic [CNT_BITS-1:0] out_cnt,
  output logic                out_bank,
  output logic                out_ovf,
  output logic                drop_stub,
  output logic                lost_bx
);

  localparam int DEPTH = 1 << CNT_BITS;
  // All-ones count is the capacity; the last word of each bank stays unused
  // so the count never has to represent DEPTH.
  localparam logic [CNT_BITS-1:0] MAX_CNT = '1;

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  // Both banks live in one array; the bank index is the address MSB.
  logic [STUB_W-1:0] mem [0:2*DEPTH-1];

  state_t              state, state_n;
  logic                wbank, wbank_n;
  logic [CNT_BITS-1:0] wcnt, wcnt_n;
  logic                wovf, wovf_n;
  logic                rd_busy, rd_busy_n;

  logic                out_ld_n;
  logic [CNT_BITS-1:0] out_cnt_n;
  logic                out_bank_n;
  logic                out_ovf_n;
  logic                drop_n;
  logic                lost_n;

  logic                wr_en;
  logic                handoff;
  logic [CNT_BITS-1:0] cnt_fin;
  logic                ovf_fin;

  // Next-state and output decode. cnt_fin/ovf_fin are the count and overflow
  // flag after this cycle's stub (if any), so a stub arriving together with
  // in_bx_end is counted in the crossing being handed off.
  always_comb begin
    state_n    = state;
    wbank_n    = wbank;
    wcnt_n     = wcnt;
    wovf_n     = wovf;
    rd_busy_n  = rd_busy;
    out_ld_n   = 1'b0;
    out_cnt_n  = out_cnt;
    out_bank_n = out_bank;
    out_ovf_n  = out_ovf;
    drop_n     = 1'b0;
    lost_n     = 1'b0;
    wr_en      = 1'b0;
    handoff    = 1'b0;
    cnt_fin    = wcnt;
    ovf_fin    = wovf;

    case (state)
      FILL: begin
        if (in_valid) begin
          if (wcnt != MAX_CNT) begin
            wr_en   = 1'b1;
            cnt_fin = wcnt + 1'b1;
          end else begin
            ovf_fin = 1'b1;
            drop_n  = 1'b1;
          end
        end
        wcnt_n = cnt_fin;
        wovf_n = ovf_fin;
        if (in_bx_end) begin
          // A release in the same cycle frees the other bank just in time.
          if (!rd_busy || proc_done) begin
            handoff = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end else if (proc_done) begin
          rd_busy_n = 1'b0;
        end
      end

      HOLD: begin
        // The completed crossing is frozen; nothing new can be stored.
        if (in_valid) begin
          drop_n = 1'b1;
        end
        if (proc_done) begin
          handoff = 1'b1;
          state_n = FILL;
        end else if (in_bx_end) begin
          lost_n = 1'b1;
        end
      end

      default: begin
        state_n = FILL;
      end
    endcase

    // Hand-off: the writer's bank becomes the reader's, the writer moves to
    // the other (just released) bank and starts a fresh crossing.
    if (handoff) begin
      out_ld_n   = 1'b1;
      out_bank_n = wbank;
      out_cnt_n  = cnt_fin;
      out_ovf_n  = ovf_fin;
      rd_busy_n  = 1'b1;
      wbank_n    = ~wbank;
      wcnt_n     = '0;
      wovf_n     = 1'b0;
    end
  end

  // Control and output registers. out_bank resets to 1 so the reader never
  // aliases the bank the writer starts filling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wbank     <= 1'b0;
      wcnt      <= '0;
      wovf      <= 1'b0;
      rd_busy   <= 1'b0;
      out_ld    <= 1'b0;
      out_cnt   <= '0;
      out_bank  <= 1'b1;
      out_ovf   <= 1'b0;
      drop_stub <= 1'b0;
      lost_bx   <= 1'b0;
    end else begin
      state     <= state_n;
      wbank     <= wbank_n;
      wcnt      <= wcnt_n;
      wovf      <= wovf_n;
      rd_busy   <= rd_busy_n;
      out_ld    <= out_ld_n;
      out_cnt   <= out_cnt_n;
      out_bank  <= out_bank_n;
      out_ovf   <= out_ovf_n;
      drop_stub <= drop_n;
      lost_bx   <= lost_n;
    end
  end

  // Stub storage write port; the writer only ever touches its own bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wbank, wcnt}] <= in_data;
    end
  end

  // Read port uses the registered out_bank, so a read issued in the out_ld
  // cycle already sees the newly handed-off bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{out_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_ts_stub_writer.sv
// ---------------------------------------------------------------------------
// tb_ts_stub_writer
//
// Self-checking bench for ts_stub_writer. A behavioural model keeps the
// current crossing as a queue of stubs and the two banks as plain arrays;
// every cycle the DUT outputs are compared against it. Directed scenarios
// are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_ts_stub_writer;

  localparam int STUB_W   = 32;
  localparam int CNT_BITS = 6;
  localparam int MAX      = (1 << CNT_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [STUB_W-1:0]   in_data;
  logic                in_bx_end;
  logic                proc_done;
  logic [CNT_BITS-1:0] rd_addr;
  logic [STUB_W-1:0]   rd_data;
  logic                out_ld;
  logic [CNT_BITS-1:0] out_cnt;
  logic                out_bank;
  logic                out_ovf;
  logic                drop_stub;
  logic                lost_bx;

  ts_stub_writer #(.STUB_W(STUB_W), .CNT_BITS(CNT_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_bx_end (in_bx_end),
    .proc_done (proc_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_ld    (out_ld),
    .out_cnt   (out_cnt),
    .out_bank  (out_bank),
    .out_ovf   (out_ovf),
    .drop_stub (drop_stub),
    .lost_bx   (lost_bx)
  );

  always #5 clk = ~clk;

  int err_count   = 0;
  int check_count = 0;

  // Behavioural model state
  logic [STUB_W-1:0] bank_data [2][64];
  logic [STUB_W-1:0] cur_q [$];
  bit                m_ovf;
  bit                m_busy;
  bit                m_hold;
  int                m_wbank;
  int                m_out_bank;
  int                m_out_cnt;
  bit                m_out_ovf;
  bit                exp_ld;

  int drop_seen;
  int lost_seen;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    cur_q.delete();
    m_ovf      = 1'b0;
    m_busy     = 1'b0;
    m_hold     = 1'b0;
    m_wbank    = 0;
    m_out_bank = 1;
    m_out_cnt  = 0;
    m_out_ovf  = 1'b0;
  endtask

  task automatic modelHandoff();
    for (int i = 0; i < cur_q.size(); i++) bank_data[m_wbank][i] = cur_q[i];
    m_out_bank = m_wbank;
    m_out_cnt  = cur_q.size();
    m_out_ovf  = m_ovf;
    exp_ld     = 1'b1;
    m_busy     = 1'b1;
    m_wbank    = 1 - m_wbank;
    cur_q.delete();
    m_ovf      = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then
  // compare every output just after the clock edge.
  task automatic applyStimulus(input bit v, input logic [STUB_W-1:0] d, input bit bx,
                               input bit pd, input int addr);
    bit                exp_drop;
    bit                exp_lost;
    bit                rd_chk;
    logic [STUB_W-1:0] exp_rd;
    in_valid  = v;
    in_data   = d;
    in_bx_end = bx;
    proc_done = pd;
    rd_addr   = addr[CNT_BITS-1:0];

    rd_chk   = (addr < m_out_cnt);
    exp_rd   = bank_data[m_out_bank][addr];
    exp_ld   = 1'b0;
    exp_drop = 1'b0;
    exp_lost = 1'b0;

    if (!m_hold) begin
      if (v) begin
        if (cur_q.size() < MAX) cur_q.push_back(d);
        else begin
          m_ovf    = 1'b1;
          exp_drop = 1'b1;
        end
      end
      if (bx) begin
        if (!m_busy || pd) modelHandoff();
        else m_hold = 1'b1;
      end else if (pd) begin
        m_busy = 1'b0;
      end
    end else begin
      if (v) exp_drop = 1'b1;
      if (pd) begin
        modelHandoff();
        m_hold = 1'b0;
      end else if (bx) begin
        exp_lost = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    checkOutput("out_ld", out_ld, exp_ld);
    checkOutput("drop_stub", drop_stub, exp_drop);
    checkOutput("lost_bx", lost_bx, exp_lost);
    checkOutput("out_cnt", out_cnt, m_out_cnt);
    checkOutput("out_bank", out_bank, m_out_bank);
    checkOutput("out_ovf", out_ovf, m_out_ovf);
    if (rd_chk) checkOutput("rd_data", rd_data, exp_rd);
    drop_seen += drop_stub;
    lost_seen += lost_bx;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must take
  // their reset values before any clock edge arrives.
  task automatic doReset();
    in_valid  = 1'b0;
    in_data   = '0;
    in_bx_end = 1'b0;
    proc_done = 1'b0;
    rd_addr   = '0;
    rst       = 1'b1;
    #2;
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_out_ld", out_ld, 0);
    checkOutput("rst_out_cnt", out_cnt, 0);
    checkOutput("rst_out_bank", out_bank, 1);
    checkOutput("rst_out_ovf", out_ovf, 0);
    checkOutput("rst_drop", drop_stub, 0);
    checkOutput("rst_lost", lost_bx, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    #3;
    doReset();

    // Five stubs, crossing end on the last one, then read them back
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hA0 + i, i == 4, 1'b0, 0);
    checkOutput("s1_ld", out_ld, 1);
    checkOutput("s1_cnt", out_cnt, 5);
    checkOutput("s1_bank", out_bank, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, i);
      checkOutput("s1_rd", rd_data, 32'hA0 + i);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);

    // Empty crossing still hands off
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    checkOutput("s2_ld", out_ld, 1);
    checkOutput("s2_cnt", out_cnt, 0);
    checkOutput("s2_bank", out_bank, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);

    // Overflow: 70 stubs into a 63-stub bank
    drop_seen = 0;
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, $urandom, i == 69, 1'b0, 0);
    checkOutput("s3_drops", drop_seen, 7);
    checkOutput("s3_cnt", out_cnt, 63);
    checkOutput("s3_ovf", out_ovf, 1);
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, i);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);

    // Crossing end while the reader is busy: HOLD, drops, lost crossing
    doReset();
    applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'hB1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'hC1, 1'b1, 1'b0, 0);
    drop_seen = 0;
    lost_seen = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hD0 + i, 1'b0, 1'b0, i);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
    checkOutput("s4_drops", drop_seen, 3);
    checkOutput("s4_lost", lost_seen, 1);
    checkOutput("s4_ld", out_ld, 1);
    checkOutput("s4_bank", out_bank, 1);
    checkOutput("s4_cnt", out_cnt, 2);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1);
    checkOutput("s4_rd", rd_data, 32'hC1);

    // Release and crossing end in the same cycle: no HOLD
    applyStimulus(1'b1, 32'hE0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'hE1, 1'b1, 1'b1, 0);
    checkOutput("s5_ld", out_ld, 1);
    checkOutput("s5_bank", out_bank, 0);
    checkOutput("s5_cnt", out_cnt, 2);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);

    // Reset in the middle of a crossing, then a fresh 2-stub crossing
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hF0 + i, 1'b0, 1'b0, 0);
    doReset();
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'h12, 1'b1, 1'b0, 0);
    checkOutput("s6_ld", out_ld, 1);
    checkOutput("s6_cnt", out_cnt, 2);
    checkOutput("s6_bank", out_bank, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
    checkOutput("s6_rd", rd_data, 32'h11);

    // Randomized traffic: short crossings first, then long ones that can
    // overflow, with the consumer releasing at random times.
    for (int i = 0; i < 4000; i++) begin
      int bx_div;
      bx_div = (i < 2000) ? 8 : 90;
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, bx_div - 1) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, MAX));
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/ts_stub_writer.md
# ts_stub_writer

Producer side of the per-crossing stub hand-off in the trigger stub path. Collects the stubs of one bunch crossing into one half of an internal ping-pong buffer. At end of crossing it hands the completed half and its stub count to the processing side. The handed-off count drives the consumer's down-counter load (`init`/`ld_en`); the consumer reads stubs back by address and releases the half with `proc_done`.

## Interface
- `STUB_W`, 32: stub word width.
- `CNT_BITS`, 6: stub count width; each bank holds at most MAX = 2^CNT_BITS - 1 stubs (63 by default).
- `clk`  in  1  fast processing clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` carries a stub this cycle.
- `in_data`  in  STUB_W  stub word.
- `in_bx_end`  in  1  last cycle of the current crossing; a stub valid in the same cycle belongs to the ending crossing.
- `proc_done`  in  1  single-cycle pulse; consumer has finished with the bank it was handed.
- `rd_addr`  in  CNT_BITS  read index into the handed-off bank.
- `rd_data`  out  STUB_W  registered read data.
- `out_ld`  out  1  single-cycle pulse; connects to consumer `ld_en`.
- `out_cnt`  out  CNT_BITS  stub count of the handed-off bank; connects to consumer `init`; held until the next `out_ld`.
- `out_bank`  out  1  index of the bank owned by the reader.
- `out_ovf`  out  1  handed-off crossing had more than MAX stubs; held with `out_cnt`.
- `drop_stub`  out  1  single-cycle pulse; a stub was discarded (overflow or HOLD).
- `lost_bx`  out  1  single-cycle pulse; a whole crossing was discarded in HOLD.

## Operation
- Two banks, each MAX+1 words deep. The writer owns bank `wbank`; the reader owns the other bank while `rd_busy` = 1.
- Writer FSM has two states:
  - **FILL**: write stubs into bank `wbank`.
  - **HOLD**: the current crossing is complete and is waiting for the reader to free the other bank.
- **FILL, stub arrives** (`in_valid` = 1):
  - If `wcnt` < MAX: write `in_data` at address `wcnt`, then `wcnt` += 1.
  - Otherwise: discard the stub, set the sticky `wovf`, pulse `drop_stub`.
- **FILL, `in_bx_end`** (after the write above, if any):
  - If `rd_busy` = 0, or `proc_done` = 1 in the same cycle: hand off. Actions:
    - `out_bank` <= `wbank`; `out_cnt` <= final `wcnt`; `out_ovf` <= final `wovf`; pulse `out_ld`; `rd_busy` <= 1.
    - `wbank` toggles; `wcnt` <= 0; `wovf` <= 0; stay in FILL.
  - Otherwise: go to HOLD with `wcnt`/`wovf` frozen.
- **HOLD**:
  - Every `in_valid` is discarded and pulses `drop_stub`.
  - `in_bx_end` without `proc_done` pulses `lost_bx`; that crossing is discarded.
  - `proc_done` performs the hand-off above (using the frozen `wcnt`/`wovf`) and returns to FILL. Stubs arriving in that same cycle are dropped.
- **Empty crossing**: still handed off with `out_cnt` = 0. The consumer must still pulse `proc_done`.
- **`proc_done` while not handing off**: `rd_busy` <= 0. A `proc_done` with `rd_busy` = 0 is ignored.
- **Read port**: `rd_data` <= bank[`out_bank`][`rd_addr`] every cycle.
  - `rd_addr` ≥ `out_cnt` returns undefined data; no error is flagged.
- **Arithmetic**: `wcnt` never wraps; it saturates at MAX. Counts are unsigned CNT_BITS.

## Timing
- **Reset values**:
  - Outputs: `rd_data` = 0, `out_ld` = 0, `out_cnt` = 0, `out_bank` = 1, `out_ovf` = 0, `drop_stub` = 0, `lost_bx` = 0.
  - Internal: FILL, `wbank` = 0, `wcnt` = 0, `wovf` = 0, `rd_busy` = 0.
- **Reset mid-operation**: all buffered data and pending hand-offs are abandoned.
- **Hand-off latency**:
  - `in_bx_end` at cycle t with the reader free → `out_ld`/`out_cnt`/`out_bank` valid at t+1.
  - A stub at t+1 is written to the new bank at address 0.
- **HOLD exit**: `proc_done` at cycle t → `out_ld` at t+1.
- **Read latency**: 1 cycle from `rd_addr` to `rd_data`. A read issued in the `out_ld` cycle returns new-bank data.
- **Write/read isolation**: a write in cycle t is never visible through the read port before hand-off.
- **Back-to-back crossings**: the writer sustains one stub per cycle and a `in_bx_end` on consecutive cycles whenever the reader keeps up.

## Test plan
- Reset, then 5 stubs 0xA0..0xA4 with `in_bx_end` on the last → `out_ld` pulses 1 cycle later with `out_cnt` = 5, `out_bank` = 0; reading addresses 0..4 returns 0xA0..0xA4.
- `in_bx_end` alone, with no stubs → `out_ld` with `out_cnt` = 0; the consumer counter's `is_zero` is high immediately.
- 70 stubs in one crossing (CNT_BITS = 6) → 63 stored, `drop_stub` pulses 7 times, `out_cnt` = 63, `out_ovf` = 1.
- Second `in_bx_end` while `rd_busy`, then 3 more stubs, then another `in_bx_end`, then `proc_done` → writer enters HOLD, 3 `drop_stub` pulses, 1 `lost_bx` pulse; after `proc_done`, `out_ld` carries the second crossing's count on bank 1.
- `proc_done` and `in_bx_end` in the same cycle → no HOLD, `out_ld` the next cycle, banks swap.
- Assert `rst` mid-crossing with 4 stubs written → every output and internal state returns to its reset value; the next crossing of 2 stubs hands off `out_cnt` = 2 on bank 0.
